// File: rtl/id_serial_tx_pkg.sv
// Shared definitions for the serial device-ID transmitter: state encodings and line levels.
package id_serial_tx_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  localparam logic IdleLevel = 1'b1;

endpackage

// File: rtl/id_tx_baud_cnt.sv
// Bit-period counter: counts 0..DIV-1 while enabled and flags the last cycle of each bit.
module id_tx_baud_cnt #(
  parameter int unsigned DIV   = 16,
  parameter int unsigned DIV_W = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] Last = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  assign tick = ~clr & (div_cnt_q == Last);

  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    if (clr || (div_cnt_q == Last)) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/id_serial_tx.sv
// UART-style transmitter for the device ID: start, ID_W data bits LSB first, optional even
// parity (enabled by defining ID_PARITY_EN), stop. All outputs are registered.
module id_serial_tx
  import id_serial_tx_pkg::*;
#(
  parameter int unsigned ID_W  = 8,
  parameter int unsigned DIV   = 16,
  parameter int unsigned DIV_W = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [ID_W-1:0] ID_IN,
  input  logic            REQ,
  output logic            SER_OUT,
  output logic            BUSY,
  output logic            DONE
);

  localparam int unsigned BitW = (ID_W > 1) ? $clog2(ID_W) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(ID_W - 1);

  tx_state_e       state_q, state_d;
  logic [ID_W-1:0] shift_q, shift_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic            ser_q, ser_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tick;
  logic            clr;
`ifdef ID_PARITY_EN
  logic            parity_q, parity_d;
`endif

  // Counter is held at zero while idle so the start bit gets a full period from the REQ edge.
  assign clr = (state_q == StIdle);

  id_tx_baud_cnt #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_baud_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef ID_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (REQ) begin
          state_d   = StStart;
          shift_d   = ID_IN;
          bit_cnt_d = '0;
`ifdef ID_PARITY_EN
          parity_d  = ^ID_IN;
`endif
        end
      end
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_cnt_q == LastBit) begin
`ifdef ID_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef ID_PARITY_EN
      StParity: begin
        if (tick) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    ser_d  = IdleLevel;
    busy_d = (state_d != StIdle);
    done_d = (state_q == StStop) && tick;
    unique case (state_d)
      StStart:  ser_d = 1'b0;
      StData:   ser_d = shift_d[0];
`ifdef ID_PARITY_EN
      StParity: ser_d = parity_d;
`endif
      StStop:   ser_d = 1'b1;
      default:  ser_d = IdleLevel;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ser_q     <= IdleLevel;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ID_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ser_q     <= ser_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef ID_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign SER_OUT = ser_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_id_serial_tx.sv
// Bench for id_serial_tx: two instances (DIV=4 and DIV=2) checked every cycle against a
// frame-level model, plus directed frames with hand-computed line patterns and latencies.
module tb_id_serial_tx;

`ifdef ID_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [1:0]      req;
  logic [1:0][7:0] id;
  logic [1:0]      ser, busy, done;
  bit              chk_en;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  id_serial_tx #(.ID_W(8), .DIV(4), .DIV_W(16)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N), .ID_IN(id[0]), .REQ(req[0]),
    .SER_OUT(ser[0]), .BUSY(busy[0]), .DONE(done[0])
  );

  id_serial_tx #(.ID_W(8), .DIV(2), .DIV_W(16)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .ID_IN(id[1]), .REQ(req[1]),
    .SER_OUT(ser[1]), .BUSY(busy[1]), .DONE(done[1])
  );

  function automatic int divof(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  // Line level of frame bit j: start, data LSB first, [parity], stop.
  function automatic logic exp_bit(input logic [7:0] v, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return v[j-1];
`ifdef ID_PARITY_EN
    if (j == 9) return ^v;
`endif
    return 1'b1;
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Frame model: a frame is NB*DIV cycles long, counted from the edge that accepts REQ.
  bit         m_act [2];
  int         m_k   [2];
  logic [7:0] m_id  [2];
  bit         m_done[2];

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i]  <= 1'b0;
        m_k[i]    <= 0;
        m_done[i] <= 1'b0;
        m_id[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= 1'b0;
        if (m_act[i]) begin
          m_k[i] <= m_k[i] + 1;
          if (m_k[i] + 1 == NB * divof(i)) begin
            m_act[i]  <= 1'b0;
            m_done[i] <= 1'b1;
          end
        end else if (req[i]) begin
          m_act[i] <= 1'b1;
          m_k[i]   <= 0;
          m_id[i]  <= id[i];
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (RST_N && chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("ser_div%0d", divof(i)), int'(ser[i]),
              m_act[i] ? int'(exp_bit(m_id[i], m_k[i] / divof(i))) : 1);
        check($sformatf("busy_div%0d", divof(i)), int'(busy[i]), int'(m_act[i]));
        check($sformatf("done_div%0d", divof(i)), int'(done[i]), int'(m_done[i]));
      end
    end
  end

  // One REQ pulse on instance s; records DONE latency, busy cycles and mid-bit line samples.
  task automatic run_frame(input int s, input logic [7:0] v, input bit meddle,
                           output int done_at, output int busy_n, output logic [11:0] line);
    int d;
    d = divof(s);
    @(posedge CLK); #2;
    id[s]  = v;
    req[s] = 1'b1;
    @(posedge CLK); #2;
    req[s] = 1'b0;
    done_at = -1;
    busy_n  = 0;
    line    = '0;
    for (int k = 0; k < 200 && done_at < 0; k++) begin
      @(negedge CLK);
      if (busy[s]) busy_n++;
      if ((k % d == d / 2) && (k / d < 12)) line[k/d] = ser[s];
      if (done[s]) done_at = k;
      if (meddle && k == 12) begin
        id[s]  = 8'h5A;
        req[s] = 1'b1;
      end
      if (meddle && k == 14) req[s] = 1'b0;
    end
  endtask

  int          done_at, busy_n, cnt;
  logic [11:0] line;
  logic [11:0] mask;
  bit          hold;

  initial begin
    RST_N  = 1'b0;
    req    = '0;
    id[0]  = 8'hB1;
    id[1]  = 8'hB1;
    chk_en = 1'b0;
    mask   = 12'((1 << NB) - 1);
    repeat (3) @(posedge CLK);
    #2;
    check("rst_ser", int'(ser[0]), 1);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_done", int'(done[0]), 0);
    RST_N  = 1'b1;
    chk_en = 1'b1;

    run_frame(0, 8'hB1, 1'b0, done_at, busy_n, line);
    check("frame_done_lat", done_at, NB * 4);
    check("frame_busy_cycles", busy_n, NB * 4);
`ifdef ID_PARITY_EN
    check("frame_line_b1", int'(line & mask), 12'h562);
    run_frame(0, 8'hB0, 1'b0, done_at, busy_n, line);
    check("frame_line_b0", int'(line & mask), 12'h760);
`else
    check("frame_line_b1", int'(line & mask), 12'h362);
`endif

    run_frame(1, 8'hB1, 1'b0, done_at, busy_n, line);
    check("div2_done_lat", done_at, NB * 2);
    check("div2_busy_cycles", busy_n, NB * 2);

    // REQ re-pulsed and ID changed mid-frame: ignored.
    run_frame(0, 8'hB1, 1'b1, done_at, busy_n, line);
`ifdef ID_PARITY_EN
    check("meddle_line", int'(line & mask), 12'h562);
`else
    check("meddle_line", int'(line & mask), 12'h362);
`endif
    repeat (10) @(negedge CLK);
    check("meddle_no_second", int'(busy[0]), 0);
    id[0] = 8'hB1;

    // Back-to-back frames with REQ held high.
    @(posedge CLK); #2;
    req[0] = 1'b1;
    cnt = 0;
    do begin
      @(negedge CLK);
      cnt++;
    end while (!done[0] && cnt < 200);
    check("b2b_done_seen", int'(done[0]), 1);
    check("b2b_done_busy", int'(busy[0]), 0);
    @(negedge CLK);
    check("b2b_restart_busy", int'(busy[0]), 1);
    check("b2b_restart_ser", int'(ser[0]), 0);
    req[0] = 1'b0;
    cnt = 0;
    while (busy[0] && cnt < 200) begin
      @(negedge CLK);
      cnt++;
    end
    check("b2b_second_ends", int'(busy[0]), 0);

    // Asynchronous reset mid-DATA (bit 1 of 8'hB1 is 0 on the line).
    @(posedge CLK); #2;
    req[0] = 1'b1;
    @(posedge CLK); #2;
    req[0] = 1'b0;
    repeat (8) @(posedge CLK);
    #2;
    check("pre_rst_ser", int'(ser[0]), 0);
    check("pre_rst_busy", int'(busy[0]), 1);
    RST_N = 1'b0;
    #1;
    check("mid_rst_ser", int'(ser[0]), 1);
    check("mid_rst_busy", int'(busy[0]), 0);
    @(posedge CLK); #2;
    RST_N = 1'b1;

    // Randomized traffic; some blocks hold REQ high for back-to-back frames.
    for (int blk = 0; blk < 30; blk++) begin
      hold = ($urandom % 4 == 0);
      repeat (100) begin
        @(posedge CLK); #2;
        for (int i = 0; i < 2; i++) begin
          req[i] = hold ? 1'b1 : ($urandom % 16 == 0);
          if ($urandom % 8 == 0) id[i] = 8'($urandom);
        end
      end
    end
    req = '0;
    repeat (100) @(posedge CLK);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
